// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller and its clients:
// RAM/IO byte bus, host-debug bus grant, UART back-pressure,
// instruction-fetch port and load/store port.
interface mem_ctrl_if;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  // Controller side
  modport slave (
    input  rdy_in, mem_din, io_buffer_full,
    input  if_req, if_addr, if_flush,
    input  ls_req, ls_we, ls_addr, ls_size, ls_wdata,
    output mem_dout, mem_a, mem_wr,
    output if_done, if_data, ls_done, ls_rdata
  );

  // Client / environment side
  modport master (
    output rdy_in, mem_din, io_buffer_full,
    output if_req, if_addr, if_flush,
    output ls_req, ls_we, ls_addr, ls_size, ls_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  if_done, if_data, ls_done, ls_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store ports
// onto an 8-bit RAM/IO bus, little-endian, with bus-steal and UART
// back-pressure stalls.
module mem_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input logic       clk_in,
  input logic       rst_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  function automatic logic is_io(input logic [31:0] a);
    return (a[RAM_ADDR_WIDTH -: 2] == 2'b11);
  endfunction

  function automatic logic [2:0] size_to_n(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    case (i)
      2'd0:    return {w[31:8], b};
      2'd1:    return {w[31:16], b, w[7:0]};
      2'd2:    return {w[31:24], b, w[15:0]};
      default: return {b, w[23:0]};
    endcase
  endfunction

  // Lanes at or above the transfer size read back as zero.
  function automatic logic [31:0] mask_bytes(input logic [31:0] w, input logic [2:0] n);
    case (n)
      3'd1:    return {24'd0, w[7:0]};
      3'd2:    return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        is_if_q, is_if_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  ip_q, ip_d;
  logic [2:0]  cp_q, cp_d;
  logic        inflight_q, inflight_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cap_q, cap_d;
  logic        prio_if_q, prio_if_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic        if_ok_s, ls_ok_s, io_block_s, wr_ok_s;
  logic [2:0]  ip_inc_s;
  logic [31:0] cap_upd_s;

  // A port is deaf in its own done cycle; flush kills a fetch request.
  assign if_ok_s    = bus.if_req & ~if_done_q & ~bus.if_flush;
  assign ls_ok_s    = bus.ls_req & ~ls_done_q;
  assign io_block_s = is_io(mem_a_q) & bus.io_buffer_full;
  assign wr_ok_s    = bus.rdy_in & ~io_block_s;
  assign ip_inc_s   = ip_q + 3'd1;
  assign cap_upd_s  = put_byte(cap_q, cp_q[1:0], bus.mem_din);

  // Write strobe drops in the same cycle the bus is stolen or the UART is full.
  assign bus.mem_wr   = mem_wr_q & wr_ok_s;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;

  // Next-state, pointer and output computation.
  always_comb begin
    state_d    = state_q;
    is_if_d    = is_if_q;
    base_d     = base_q;
    n_d        = n_q;
    ip_d       = ip_q;
    cp_d       = cp_q;
    inflight_d = inflight_q;
    wdata_d    = wdata_q;
    cap_d      = cap_q;
    prio_if_d  = prio_if_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ls_ok_s && !(prio_if_q && if_ok_s)) begin
          is_if_d    = 1'b0;
          base_d     = bus.ls_addr;
          n_d        = size_to_n(bus.ls_size);
          ip_d       = 3'd0;
          cp_d       = 3'd0;
          inflight_d = 1'b0;
          mem_a_d    = bus.ls_addr;
          wdata_d    = bus.ls_wdata;
          prio_if_d  = if_ok_s;  // a fetch kept waiting goes first next time
          if (bus.ls_we) begin
            state_d    = ST_WRITE;
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.ls_wdata[7:0];
          end else begin
            state_d    = ST_READ;
            mem_wr_d   = 1'b0;
          end
        end else if (if_ok_s) begin
          is_if_d    = 1'b1;
          base_d     = bus.if_addr;
          n_d        = 3'd4;
          ip_d       = 3'd0;
          cp_d       = 3'd0;
          inflight_d = 1'b0;
          mem_a_d    = bus.if_addr;
          mem_wr_d   = 1'b0;
          prio_if_d  = 1'b0;
          state_d    = ST_READ;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_READ: begin
        if (is_if_q && bus.if_flush) begin
          state_d    = ST_IDLE;
          inflight_d = 1'b0;
        end else if (bus.rdy_in) begin
          if (inflight_q && ((cp_q + 3'd1) == n_q)) begin
            state_d    = ST_IDLE;
            inflight_d = 1'b0;
            cap_d      = cap_upd_s;
            cp_d       = cp_q + 3'd1;
            if (is_if_q) begin
              if_done_d  = 1'b1;
              if_data_d  = cap_upd_s;
            end else begin
              ls_done_d  = 1'b1;
              ls_rdata_d = mask_bytes(cap_upd_s, n_q);
            end
          end else begin
            if (inflight_q) begin
              cap_d = cap_upd_s;
              cp_d  = cp_q + 3'd1;
            end else begin
              cap_d = cap_q;
            end
            if (ip_q < n_q) begin
              ip_d       = ip_inc_s;
              inflight_d = 1'b1;
              if (ip_inc_s < n_q) begin
                mem_a_d = base_q + {29'd0, ip_inc_s};
              end else begin
                mem_a_d = mem_a_q;
              end
            end else begin
              inflight_d = 1'b0;
            end
          end
        end else begin
          // Bus stolen: the byte in flight is lost, re-issue from the capture point.
          ip_d       = cp_q;
          inflight_d = 1'b0;
          mem_a_d    = base_q + {29'd0, cp_q};
        end
      end
      ST_WRITE: begin
        if (wr_ok_s) begin
          if (ip_inc_s == n_q) begin
            state_d   = ST_IDLE;
            mem_wr_d  = 1'b0;
            ls_done_d = 1'b1;
          end else begin
            ip_d       = ip_inc_s;
            mem_a_d    = base_q + {29'd0, ip_inc_s};
            mem_dout_d = sel_byte(wdata_q, ip_inc_s[1:0]);
          end
        end else begin
          ip_d = ip_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      is_if_q    <= 1'b0;
      base_q     <= 32'd0;
      n_q        <= 3'd0;
      ip_q       <= 3'd0;
      cp_q       <= 3'd0;
      inflight_q <= 1'b0;
      wdata_q    <= 32'd0;
      cap_q      <= 32'd0;
      prio_if_q  <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      is_if_q    <= is_if_d;
      base_q     <= base_d;
      n_q        <= n_d;
      ip_q       <= ip_d;
      cp_q       <= cp_d;
      inflight_q <= inflight_d;
      wdata_q    <= wdata_d;
      cap_q      <= cap_d;
      prio_if_q  <= prio_if_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of single transactions with
// rdy_in high, plus hand-written stall / flush / arbitration / reset sequences.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] ram [0:262143];

  mem_ctrl_if bus();

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Byte RAM model: one-cycle read latency, garbage while the bus is stolen.
  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
    bus.mem_din <= bus.rdy_in ? ram[bus.mem_a[17:0]] : 8'hEE;
  end

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int cyc;
    logic got;
    logic [31:0] a;
    logic [31:0] wb;
    n = v.is_ls ? ((v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4) : 4;
    if (v.is_ls) begin
      bus.ls_req = 1'b1; bus.ls_we = v.we; bus.ls_addr = v.addr;
      bus.ls_size = v.size; bus.ls_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    step();
    bus.ls_req = 1'b0;
    bus.if_req = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (cyc <= n) begin
        a = v.addr + 32'(cyc - 1);
        chk($sformatf("v%0d addr c%0d", idx, cyc), bus.mem_a, a);
        if (v.we) begin
          wb = v.wdata >> (8 * (cyc - 1));
          chk($sformatf("v%0d wr c%0d", idx, cyc), {31'd0, bus.mem_wr}, 32'd1);
          chk($sformatf("v%0d dout c%0d", idx, cyc), {24'd0, bus.mem_dout}, {24'd0, wb[7:0]});
        end
      end
      got = v.is_ls ? bus.ls_done : bus.if_done;
      if (!got) begin
        step();
        cyc++;
      end
    end
    chk($sformatf("v%0d done cycle", idx), 32'(cyc), 32'(v.exp_cyc));
    if (!v.we) begin
      chk($sformatf("v%0d data", idx), v.is_ls ? bus.ls_rdata : bus.if_data, v.exp_data);
    end
    step();
    chk($sformatf("v%0d done pulse", idx), {31'd0, (v.is_ls ? bus.ls_done : bus.if_done)}, 32'd0);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int cnt;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h00; ram[18'h00102] = 8'h00; ram[18'h00103] = 8'h93;
    ram[18'h00200] = 8'h78; ram[18'h00201] = 8'h56; ram[18'h00202] = 8'h34; ram[18'h00203] = 8'h12;
    ram[18'h001FE] = 8'hCD; ram[18'h001FF] = 8'hAB;
    ram[18'h3FFFE] = 8'h11; ram[18'h3FFFF] = 8'h22; ram[18'h00000] = 8'h33; ram[18'h00001] = 8'h44;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 2'd2, 32'd0,          32'h9300_0013, 6};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 2'd2, 32'd0,          32'h1234_5678, 6};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0203, 2'd0, 32'd0,          32'h0000_0012, 3};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_01FE, 2'd1, 32'd0,          32'h0000_ABCD, 4};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0300, 2'd2, 32'hDEAD_BEEF,  32'd0,         5};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0300, 2'd2, 32'd0,          32'hDEAD_BEEF, 6};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0400, 2'd1, 32'hAAAA_BEEF,  32'd0,         3};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0400, 2'd3, 32'd0,          32'h0000_BEEF, 6};
    vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'd0,          32'h4433_2211, 6};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_0200, 2'd2, 32'd0,          32'h1234_5678, 6};

    rst_n = 1'b0;
    bus.rdy_in = 1'b1; bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = 32'd0; bus.ls_size = 2'd0; bus.ls_wdata = 32'd0;
    #1;
    chk("rst mem_a", bus.mem_a, 32'd0);
    chk("rst mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    chk("rst dones", {30'd0, bus.if_done, bus.ls_done}, 32'd0);
    chk("rst if_data", bus.if_data, 32'd0);
    chk("rst ls_rdata", bus.ls_rdata, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Arbitration: LS first, then the waiting fetch wins over a fresh LS.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h200; bus.ls_size = 2'd2;
    step();
    chk("arb ls first", bus.mem_a, 32'h200);
    cyc = 1;
    while (!bus.ls_done && cyc < 20) begin step(); cyc++; end
    chk("arb ls_done", {31'd0, bus.ls_done}, 32'd1);
    chk("arb ls data", bus.ls_rdata, 32'h1234_5678);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    step();
    bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.ls_addr = 32'h203; bus.ls_size = 2'd0;
    step();
    chk("arb if wins", bus.mem_a, 32'h100);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    cyc = 1;
    while (!bus.if_done && cyc < 20) begin step(); cyc++; end
    chk("arb if cycle", 32'(cyc), 32'd6);
    chk("arb if data", bus.if_data, 32'h9300_0013);
    step();

    // UART-full stall on an I/O byte store.
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h30000; bus.ls_size = 2'd0;
    bus.ls_wdata = 32'h41; bus.io_buffer_full = 1'b1;
    step();
    bus.ls_req = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      if (bus.mem_wr) cnt++;
      step();
    end
    chk("io blocked wr cycles", 32'(cnt), 32'd0);
    bus.io_buffer_full = 1'b0;
    #1;
    chk("io wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("io addr", bus.mem_a, 32'h30000);
    chk("io dout", {24'd0, bus.mem_dout}, 32'h41);
    step();
    chk("io ls_done", {31'd0, bus.ls_done}, 32'd1);
    chk("io wr off", {31'd0, bus.mem_wr}, 32'd0);
    chk("io ram", {24'd0, ram[18'h30000]}, 32'h41);
    step();

    // Bus stolen for three cycles during lh 0x1FE.
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h1FE; bus.ls_size = 2'd1;
    step();
    chk("rdy c1 addr", bus.mem_a, 32'h1FE);
    bus.ls_req = 1'b0;
    step();
    bus.rdy_in = 1'b0;
    step(); step(); step();
    bus.rdy_in = 1'b1;
    chk("rdy reissue", bus.mem_a, 32'h1FE);
    cyc = 5;
    while (!bus.ls_done && cyc < 30) begin step(); cyc++; end
    chk("rdy done cycle", 32'(cyc), 32'd8);
    chk("rdy data", bus.ls_rdata, 32'h0000_ABCD);
    step();

    // Flush in cycle 3 of a fetch; pending LS accepted after.
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    step();
    bus.if_req = 1'b0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h200; bus.ls_size = 2'd2;
    step();
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    chk("flush no done", {31'd0, bus.if_done}, 32'd0);
    step();
    chk("flush ls next", bus.mem_a, 32'h200);
    bus.ls_req = 1'b0;
    cnt = 0; cyc = 5;
    while (!bus.ls_done && cyc < 30) begin
      if (bus.if_done) cnt++;
      step(); cyc++;
    end
    chk("flush ls data", bus.ls_rdata, 32'h1234_5678);
    chk("flush if_done count", 32'(cnt), 32'd0);
    chk("flush if_data held", bus.if_data, 32'h9300_0013);
    step();

    // Flush on the final capture edge suppresses if_done.
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    step();
    bus.if_req = 1'b0;
    step(); step(); step(); step();
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    chk("late flush no done", {31'd0, bus.if_done}, 32'd0);
    chk("late flush data held", bus.if_data, 32'h9300_0013);

    // Flush in IDLE discards the coincident fetch request.
    bus.if_req = 1'b1; bus.if_flush = 1'b1; bus.if_addr = 32'h100;
    step();
    bus.if_req = 1'b0; bus.if_flush = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.if_done) cnt++;
      step();
    end
    chk("idle flush no fetch", 32'(cnt), 32'd0);

    // Reset in the middle of a word store.
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h500; bus.ls_size = 2'd2;
    bus.ls_wdata = 32'h1122_3344;
    step();
    bus.ls_req = 1'b0;
    step(); step();
    chk("rst pre wr", {31'd0, bus.mem_wr}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst mid wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst mid a", bus.mem_a, 32'd0);
    chk("rst mid dout", {24'd0, bus.mem_dout}, 32'd0);
    chk("rst mid data", bus.if_data | bus.ls_rdata, 32'd0);
    step(); step();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.ls_done || bus.mem_wr) cnt++;
      step();
    end
    chk("rst no done/wr", 32'(cnt), 32'd0);
    chk("rst ram b1", {24'd0, ram[18'h00501]}, 32'h33);
    chk("rst ram b2", {24'd0, ram[18'h00502]}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
